ioctl_vram_loader: RTL and testbench

IOCTL_VRAM_LOADER -- requirements
Module: ioctl_vram_loader

---
 rtl/ioctl_vram_loader_pkg.sv | 29 ++
 rtl/ioctl_vram_loader_fifo.sv | 74 +++++++
 rtl/ioctl_vram_loader.sv | 136 +++++++++++++
 tb/tb_ioctl_vram_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_vram_loader_pkg.sv
// Purpose : shared types for the ioctl -> video RAM loader (FSM states, FIFO entry).
// Latency : n/a (types and helpers only).
// Backpressure: n/a.
package ioctl_vram_loader_pkg;

  // Width of the HPS byte address; the FIFO keeps the whole address so the
  // entry layout does not depend on the RAM size chosen at the top level.
  localparam int ENTRY_AW = 25;

  localparam logic [ENTRY_AW-1:0] BYTE_COUNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [7:0]          data;
  } fifo_entry_t;

  // True when every address bit at or above position aw is zero.
  function automatic logic addr_in_range(input logic [ENTRY_AW-1:0] addr, input int aw);
    return (addr >> aw) == '0;
  endfunction

endpackage

// File: rtl/ioctl_vram_loader_fifo.sv
// Purpose : small byte FIFO with registered empty/full/almost-full flags.
// Latency : a push is visible on o_head / o_empty the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored; o_almost_full flags count >= DEPTH-1.
// Ports   : i_clk, i_reset (sync, active-high), i_push/i_din, i_pop, o_head, o_empty, o_full, o_almost_full.
module loader_fifo
  import ioctl_vram_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_push,
  input  fifo_entry_t i_din,
  input  logic        i_pop,
  output fifo_entry_t o_head,
  output logic        o_empty,
  output logic        o_full,
  output logic        o_almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST_C = CW'(DEPTH - 1);

  fifo_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_empty;
  logic          r_full;
  logic          r_almost_full;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;

  assign w_push      = i_push & ~r_full;
  assign w_pop       = i_pop & ~r_empty;
  // Simultaneous push and pop cancel out, leaving the occupancy unchanged.
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count       <= w_count_nxt;
      r_empty       <= (w_count_nxt == '0);
      r_full        <= (w_count_nxt == DEPTH_C);
      r_almost_full <= (w_count_nxt >= ALMOST_C);
    end
  end

  assign o_head        = r_mem[r_rd_ptr];
  assign o_empty       = r_empty;
  assign o_full        = r_full;
  assign o_almost_full = r_almost_full;

endmodule

// File: rtl/ioctl_vram_loader.sv
// Purpose : copies an HPS ioctl download into video RAM through a small byte FIFO.
// Latency : a byte strobed at cycle N is on ram_we at N+1 when the FIFO was empty.
// Backpressure: ioctl_wait rises at FIFO occupancy >= FIFO_DEPTH-1 (one slot kept for a byte in flight); ram_we holds until ram_grant.
// Ports   : clk_sys/reset; ioctl_* download side; ram_addr/ram_data/ram_we/ram_grant write side;
//           progress, done, overflow, byte_count status.
module ioctl_vram_loader
  import ioctl_vram_loader_pkg::*;
#(
  parameter logic [7:0] TARGET_INDEX = 8'd0,
  parameter int         RAM_AW       = 14,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  input  logic              ram_grant,
  output logic              progress,
  output logic              done,
  output logic              overflow,
  output logic [24:0]       byte_count
);

  state_t      r_state;
  logic        r_progress;
  logic        r_done;
  logic        r_overflow;
  logic [24:0] r_byte_count;

  fifo_entry_t w_entry;
  fifo_entry_t w_head;
  logic        w_empty;
  logic        w_full;
  logic        w_almost_full;
  logic        w_strobe;
  logic        w_in_range;
  logic        w_push;
  logic        w_drop;
  logic        w_pop;

  // Only strobes in LOAD for our index count; a later index change just masks strobes.
  assign w_strobe   = (r_state == ST_LOAD) && ioctl_wr && (ioctl_index == TARGET_INDEX);
  assign w_in_range = addr_in_range(ioctl_addr, RAM_AW);
  assign w_push     = w_strobe && w_in_range && !w_full;
  assign w_drop     = w_strobe && (!w_in_range || w_full);
  assign w_pop      = !w_empty && ram_grant;

  assign w_entry.addr = ioctl_addr;
  assign w_entry.data = ioctl_dout;

  loader_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk         (clk_sys),
    .i_reset       (reset),
    .i_push        (w_push),
    .i_din         (w_entry),
    .i_pop         (w_pop),
    .o_head        (w_head),
    .o_empty       (w_empty),
    .o_full        (w_full),
    .o_almost_full (w_almost_full)
  );

  // Upper address bits of a buffered entry are always zero (out-of-range bytes never enter).
  generate
    if (RAM_AW < ENTRY_AW) begin : g_head_hi
      logic w_unused_head_hi;
      assign w_unused_head_hi = |w_head.addr[ENTRY_AW-1:RAM_AW];
    end
  endgenerate

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_progress   <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_byte_count <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_pop && (r_byte_count != BYTE_COUNT_MAX)) begin
        r_byte_count <= r_byte_count + 25'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (ioctl_download && (ioctl_index == TARGET_INDEX)) begin
            r_state      <= ST_LOAD;
            r_progress   <= 1'b1;
            r_byte_count <= '0;
            r_overflow   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!ioctl_download) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Registered empty: the last pop is complete before DONE is entered.
          if (w_empty) begin
            r_state    <= ST_DONE;
            r_progress <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ioctl_wait = w_almost_full;
  assign ram_we     = !w_empty;
  assign ram_addr   = w_head.addr[RAM_AW-1:0];
  assign ram_data   = w_head.data;
  assign progress   = r_progress;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign byte_count = r_byte_count;

endmodule

// File: tb/tb_ioctl_vram_loader.sv
// Purpose : scoreboard bench for ioctl_vram_loader; directed downloads with hand-computed expectations.
// Latency : n/a.
// Backpressure: the HPS model honours ioctl_wait unless a test forces an in-flight strobe.
module tb_ioctl_vram_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic [13:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we;
  logic        ram_grant;
  logic        progress;
  logic        done;
  logic        overflow;
  logic [24:0] byte_count;

  int n_checks = 0;
  int n_errors = 0;
  int writes   = 0;
  int done_cnt = 0;
  logic [21:0] exp_q[$];

  always #5 clk_sys = ~clk_sys;

  ioctl_vram_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .ram_addr       (ram_addr),
    .ram_data       (ram_data),
    .ram_we         (ram_we),
    .ram_grant      (ram_grant),
    .progress       (progress),
    .done           (done),
    .overflow       (overflow),
    .byte_count     (byte_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every granted write must match the head of the expected queue.
  always @(negedge clk_sys) begin
    if (!reset && ram_we && ram_grant) begin
      writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {ram_addr, ram_data}, 32'hFFFF_FFFF);
      end else begin
        chk("write_addr_data", {ram_addr, ram_data}, exp_q.pop_front());
      end
    end
    if (!reset && done) begin
      done_cnt++;
      chk("progress_low_at_done", progress, 0);
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    ioctl_wr = 1'b0;
    repeat (n) tick();
  endtask

  // One strobe; leaves ioctl_wr high so back-to-back calls strobe every cycle.
  task automatic strobe(input logic [24:0] a, input logic [7:0] d, input bit honour, input bit accept);
    int n = 0;
    if (honour) begin
      while (ioctl_wait && n < 200) begin
        ioctl_wr = 1'b0;
        tick();
        n++;
      end
      if (ioctl_wait) chk("wait_timeout", 1, 0);
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (accept) exp_q.push_back({a[13:0], d});
    tick();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    int w0;
    int d0;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int d0;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; ioctl_index = 8'd0; ram_grant = 1'b1;
    repeat (3) tick();
    chk("rst_ram_we", ram_we, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_progress", progress, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data", ram_data, 0);
    reset = 1'b0;
    tick();

    // 16-byte download, grant always high.
    w0 = writes; d0 = done_cnt;
    ioctl_download = 1'b1;
    tick();
    chk("a_progress", progress, 1);
    chk("a_we_before", ram_we, 0);
    strobe(25'd0, 8'hA0, 1, 1);
    chk("a_latency_we", ram_we, 1);
    chk("a_latency_addr", ram_addr, 0);
    chk("a_latency_data", ram_data, 8'hA0);
    for (int i = 1; i < 16; i++) strobe(25'(i), 8'hA0 + 8'(i), 1, 1);
    ioctl_download = 1'b0;
    idle(1);
    wait_done();
    chk("a_byte_count", byte_count, 16);
    idle(3);
    chk("a_writes", writes - w0, 16);
    chk("a_done_pulses", done_cnt - d0, 1);
    chk("a_queue_empty", exp_q.size(), 0);

    // Grant stalled: wait must rise at occupancy 3, nothing lost.
    w0 = writes;
    ram_grant = 1'b0;
    ioctl_download = 1'b1;
    tick();
    strobe(25'h10, 8'h51, 1, 1);
    strobe(25'h11, 8'h52, 1, 1);
    chk("b_wait_at_2", ioctl_wait, 0);
    strobe(25'h12, 8'h53, 1, 1);
    chk("b_wait_at_3", ioctl_wait, 1);
    idle(17);
    chk("b_wait_held", ioctl_wait, 1);
    chk("b_we_held", ram_we, 1);
    ram_grant = 1'b1;
    for (int i = 0; i < 5; i++) strobe(25'h13 + 25'(i), 8'h54 + 8'(i), 1, 1);
    ioctl_download = 1'b0;
    idle(1);
    wait_done();
    chk("b_byte_count", byte_count, 8);
    chk("b_overflow", overflow, 0);
    idle(3);
    chk("b_writes", writes - w0, 8);

    // In-flight byte fills the last slot; one more is dropped.
    w0 = writes;
    ram_grant = 1'b0;
    ioctl_download = 1'b1;
    tick();
    strobe(25'h20, 8'h61, 1, 1);
    strobe(25'h21, 8'h62, 1, 1);
    strobe(25'h22, 8'h63, 1, 1);
    strobe(25'h23, 8'h64, 0, 1);
    chk("c_overflow_at_full", overflow, 0);
    strobe(25'h24, 8'h65, 0, 0);
    idle(1);
    chk("c_overflow_dropped", overflow, 1);
    ram_grant = 1'b1;
    ioctl_download = 1'b0;
    wait_done();
    chk("c_byte_count", byte_count, 4);
    chk("c_overflow_sticky", overflow, 1);
    idle(3);
    chk("c_writes", writes - w0, 4);

    // Out-of-range address is dropped; overflow clears on a new load.
    w0 = writes;
    ioctl_download = 1'b1;
    tick();
    chk("d_overflow_cleared", overflow, 0);
    strobe(25'd5, 8'h11, 1, 1);
    strobe(25'd16384, 8'h22, 1, 0);
    strobe(25'd6, 8'h33, 1, 1);
    idle(1);
    chk("d_overflow", overflow, 1);
    ioctl_download = 1'b0;
    wait_done();
    chk("d_byte_count", byte_count, 2);
    idle(3);
    chk("d_writes", writes - w0, 2);

    // Foreign index: no load at all.
    w0 = writes; d0 = done_cnt;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      strobe(25'(i), 8'h70 + 8'(i), 1, 0);
      chk("e_progress", progress, 0);
    end
    ioctl_download = 1'b0;
    idle(5);
    chk("e_writes", writes - w0, 0);
    chk("e_no_done", done_cnt - d0, 0);
    ioctl_index = 8'd0;

    // Download ends with 3 bytes buffered; DRAIN ignores strobes.
    w0 = writes;
    ram_grant = 1'b0;
    ioctl_download = 1'b1;
    tick();
    strobe(25'h30, 8'h81, 1, 1);
    strobe(25'h31, 8'h82, 1, 1);
    strobe(25'h32, 8'h83, 1, 1);
    ioctl_download = 1'b0;
    idle(1);
    chk("f_progress_drain", progress, 1);
    strobe(25'h33, 8'h84, 0, 0);
    ioctl_wr = 1'b0;
    ram_grant = 1'b1;
    wait_done();
    chk("f_byte_count", byte_count, 3);
    idle(3);
    chk("f_writes", writes - w0, 3);

    // Reset mid-load with grant stalled.
    w0 = writes;
    ram_grant = 1'b0;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) strobe(25'h100 + 25'(i), 8'h91 + 8'(i), 0, 0);
    ioctl_wr = 1'b0;
    chk("g_pre_we", ram_we, 1);
    chk("g_pre_overflow", overflow, 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    chk("g_rst_we", ram_we, 0);
    chk("g_rst_wait", ioctl_wait, 0);
    chk("g_rst_progress", progress, 0);
    chk("g_rst_done", done, 0);
    chk("g_rst_overflow", overflow, 0);
    chk("g_rst_byte_count", byte_count, 0);
    chk("g_rst_ram_addr", ram_addr, 0);
    chk("g_rst_ram_data", ram_data, 0);
    reset = 1'b0;
    ram_grant = 1'b1;
    idle(10);
    chk("g_no_writes_after", writes - w0, 0);
    chk("g_progress_after", progress, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
